hp_mem_responder: RTL and testbench
===================================

// Module: hp_mem_responder
// PURPOSE
//  AXI4 (full, burst) slave responder for the kernel's 128-bit HP master port: terminates hp_* bursts in an on-chip SRAM.
//  Used as the memory end of the HP interface in simulation and on-FPGA bring-up (write/read benchmark, checksum checks).
//  Independent write and read engines. Single outstanding transaction per direction.
// PARAMETERS
//  ADDR_WIDTH      48         AXI address width
//  DATA_WIDTH      128        AXI data width; BYTES = DATA_WIDTH/8, OFS = log2(BYTES)
//  MEM_DEPTH_LOG2  10         SRAM depth in DATA_WIDTH words (default 16 KiB)
//  BASE_ADDR       48'h0      byte address of SRAM word 0
// PORTS
//  clk          in   1      clock
//  rstn         in   1      async active-low reset
//  hp_awaddr    in   ADDR   write burst start byte address
//  hp_awlen     in   8      beats-1
//  hp_awsize    in   3      bytes/beat = 2**awsize
//  hp_awburst   in   2      00 FIXED, 01 INCR, 10 WRAP, 11 rsvd
//  hp_awvalid   in   1  /  hp_awready  out 1
//  hp_wdata     in   DATA   write data
//  hp_wstrb     in   BYTES  byte enables
//  hp_wlast     in   1      last write beat
//  hp_wvalid    in   1  /  hp_wready   out 1
//  hp_bresp     out  2      00 OKAY, 10 SLVERR, 11 DECERR
//  hp_bvalid    out  1  /  hp_bready   in  1
//  hp_araddr, hp_arlen, hp_arsize, hp_arburst   in   as AW    read burst
//  hp_arvalid   in   1  /  hp_arready  out 1
//  hp_rdata     out  DATA   read data
//  hp_rresp     out  2      per-beat response
//  hp_rlast     out  1      final read beat
//  hp_rvalid    out  1  /  hp_rready   in  1
// BEHAVIOUR
//  Reset: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp, rdata = 0; SRAM contents not reset.
//  Reset mid-burst: both FSMs return to idle immediately. The burst is dropped, with no response.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE
//   W_IDLE: awready=1. On AW handshake, latch addr/len/burst/size, clear err, beat counter cnt=0.
//   W_DATA: awready=0, wready=1. Per W handshake:
//    - word-write SRAM at idx=(addr-BASE_ADDR)>>OFS with wstrb;
//    - INCR: addr += BYTES; FIXED: addr held; cnt++.
//   End of W_DATA: the beat with wlast=1 ends it. Then wready=0, bvalid=1 on the next cycle.
//   SLVERR (writes still done): wlast seen at cnt!=len, or wlast absent at cnt==len. In the second case, continue accepting until wlast.
//   Burst-level SLVERR (SRAM writes suppressed for the whole burst): awsize!=OFS, or awburst in {10,11}.
//   DECERR: any beat out of range, i.e. addr<BASE_ADDR or idx>=2**MEM_DEPTH_LOG2. That beat's write is suppressed.
//   Response priority: DECERR > SLVERR > OKAY.
//   W_RESP: bvalid held until bready. Back to W_IDLE on handshake; awready=1 on the following cycle.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE
//   R_IDLE: arready=1. AR handshake at cycle T: latch fields; first beat rvalid=1 at T+1.
//   Output register (rdata/rresp/rlast) loads when (!rvalid || rready) and beats remain. This gives 1 beat/cycle under continuous rready.
//   rlast=1 exactly on beat arlen. R_IDLE follows the rlast handshake.
//   Error beats: DECERR/SLVERR use the same rules as writes, per beat on rresp, with rdata=0.
//   rdata/rresp stable while rvalid && !rready.
//  Simultaneous read/write of the same word in one cycle: read returns old data (read-first).
//  Address arithmetic: ADDR_WIDTH bits, wraps modulo 2**ADDR_WIDTH. 4 KiB crossing is not checked.
// STRUCTURE
//  hp_mem_pkg:
//   - burst_t: FIXED, INCR, WRAP, RSVD
//   - resp_t: OKAY, EXOKAY, SLVERR, DECERR
//   - wr_state_t, rd_state_t
//   - function resp_max()
//  Sub-module hp_mem_sram:
//   - true dual-port, 1 write port with byte enables, 1 registered read port, read-first
//   - depth 2**MEM_DEPTH_LOG2
// TESTING
//  1) AW addr=BASE+0x100 len=3 INCR size=4, 4 beats data 0x..0-0x..3 strb all-ones, then AR same -> bresp=00; R beats 0..3 back-to-back, rlast on beat 3, rresp=00.
//  2) Write strb=16'h00FF over 0xFF..FF word -> read gives upper 8 bytes 0xFF, lower = new data.
//  3) AR len=7 with rready toggling 1,0,0,1 -> no beat lost or duplicated; rdata stable while stalled; 8 beats total.
//  4) AW addr=BASE+(2**MEM_DEPTH_LOG2-2)*16 len=3 -> beats 0,1 written; bresp=11. Matching read -> rresp 00,00,11,11 and rdata=0 on beats 2,3.
//  5) AW len=3 with wlast on beat 1 -> bresp=10. awburst=WRAP -> bresp=10 and SRAM unchanged.
//  6) Concurrent write burst and read burst to the same word, plus rstn pulse mid read burst -> read-first data; after reset rvalid=0, arready=1, next burst OKAY.

Source files
------------

// File: rtl/hp_mem_pkg.sv
// Shared types for the HP AXI4 memory responder.
package hp_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Encoding order already ranks DECERR > SLVERR > OKAY.
  function automatic resp_t resp_max(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hp_mem_sram.sv
// Dual-port SRAM: byte-enabled write port, registered read-first read port.
module hp_mem_sram #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we_i,
  input  logic [DEPTH_LOG2-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic                    rzero_i,
  input  logic [DEPTH_LOG2-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-masked write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Read register only advances on re_i, so data holds during stalls; error beats read as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     rdata_q <= '0;
    else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hp_mem_responder.sv
// AXI4 burst slave terminating the HP master port in on-chip SRAM.
module hp_mem_responder
  import hp_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 48,
  parameter int unsigned           DATA_WIDTH     = 128,
  parameter int unsigned           MEM_DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]              hp_awlen,
  input  logic [2:0]              hp_awsize,
  input  logic [1:0]              hp_awburst,
  input  logic                    hp_awvalid,
  output logic                    hp_awready,
  input  logic [DATA_WIDTH-1:0]   hp_wdata,
  input  logic [DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                    hp_wlast,
  input  logic                    hp_wvalid,
  output logic                    hp_wready,
  output logic [1:0]              hp_bresp,
  output logic                    hp_bvalid,
  input  logic                    hp_bready,
  input  logic [ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]              hp_arlen,
  input  logic [2:0]              hp_arsize,
  input  logic [1:0]              hp_arburst,
  input  logic                    hp_arvalid,
  output logic                    hp_arready,
  output logic [DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]              hp_rresp,
  output logic                    hp_rlast,
  output logic                    hp_rvalid,
  input  logic                    hp_rready
);

  localparam int unsigned           BYTES = DATA_WIDTH / 8;
  localparam int unsigned           OFS   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BYTES);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> (OFS + MEM_DEPTH_LOG2)) != '0);
  endfunction

  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_DEPTH_LOG2'((a - BASE_ADDR) >> OFS);
  endfunction

  // Narrow beats and WRAP/reserved bursts are rejected for the whole burst.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (size != 3'(OFS)) || (burst_t'(burst) == BURST_WRAP) || (burst_t'(burst) == BURST_RSVD);
  endfunction

  // ---------------- write engine ----------------
  wr_state_t             wstate_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic                  wincr_q, wbad_q;
  resp_t                 wresp_q, bresp_q;
  logic                  awready_q, wready_q, bvalid_q;

  logic  w_hs, w_oor;
  resp_t w_beat_resp;

  // Per-beat response folded into the burst response; wlast must coincide with beat awlen.
  always_comb begin
    w_hs        = (wstate_q == W_DATA) && hp_wvalid && wready_q;
    w_oor       = out_of_range(waddr_q);
    w_beat_resp = resp_max(wresp_q,
                  resp_max(w_oor ? RESP_DECERR : RESP_OKAY,
                           (hp_wlast != (wcnt_q == wlen_q)) ? RESP_SLVERR : RESP_OKAY));
  end

  // Write FSM: accept AW, absorb beats until wlast, hold B until bready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wincr_q   <= 1'b0;
      wbad_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (hp_awvalid && awready_q) begin
            waddr_q   <= hp_awaddr;
            wlen_q    <= hp_awlen;
            wcnt_q    <= '0;
            wincr_q   <= (burst_t'(hp_awburst) == BURST_INCR);
            wbad_q    <= burst_bad(hp_awburst, hp_awsize);
            wresp_q   <= burst_bad(hp_awburst, hp_awsize) ? RESP_SLVERR : RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wresp_q <= w_beat_resp;
            wcnt_q  <= 8'(wcnt_q + 8'd1);
            if (wincr_q) waddr_q <= waddr_q + STEP;
            if (hp_wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= w_beat_resp;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (hp_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_t             rstate_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic                  rincr_q, rbad_q;
  logic                  arready_q, rvalid_q, rlast_q;
  resp_t                 rresp_q;

  logic                  ar_hs, r_load, r_bad, r_incr, r_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  resp_t                 r_resp;

  // Next beat comes from AR directly on the handshake cycle, otherwise from the latched burst.
  always_comb begin
    ar_hs  = (rstate_q == R_IDLE) && hp_arvalid && arready_q;
    r_load = ar_hs || ((rstate_q == R_DATA) && (!rvalid_q || hp_rready) && !rlast_q);
    r_addr = ar_hs ? hp_araddr : raddr_q;
    r_bad  = ar_hs ? burst_bad(hp_arburst, hp_arsize) : rbad_q;
    r_incr = ar_hs ? (burst_t'(hp_arburst) == BURST_INCR) : rincr_q;
    r_last = ar_hs ? (hp_arlen == 8'd0) : (8'(rcnt_q + 8'd1) == rlen_q);
    r_resp = resp_max(out_of_range(r_addr) ? RESP_DECERR : RESP_OKAY,
                      r_bad ? RESP_SLVERR : RESP_OKAY);
  end

  // Read FSM: one beat per cycle under continuous rready, outputs frozen while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rincr_q   <= 1'b0;
      rbad_q    <= 1'b0;
    end else begin
      if (r_load) begin
        rvalid_q <= 1'b1;
        rlast_q  <= r_last;
        rresp_q  <= r_resp;
        raddr_q  <= r_incr ? r_addr + STEP : r_addr;
      end
      if (ar_hs) begin
        rlen_q    <= hp_arlen;
        rcnt_q    <= '0;
        rincr_q   <= r_incr;
        rbad_q    <= r_bad;
        arready_q <= 1'b0;
        rstate_q  <= R_DATA;
      end else if (rstate_q == R_DATA) begin
        if (r_load) begin
          rcnt_q <= 8'(rcnt_q + 8'd1);
        end else if (hp_rready && rlast_q) begin
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          arready_q <= 1'b1;
          rstate_q  <= R_IDLE;
        end
      end
    end
  end

  hp_mem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (w_hs && !wbad_q && !w_oor),
    .waddr_i (word_idx(waddr_q)),
    .wdata_i (hp_wdata),
    .wstrb_i (hp_wstrb),
    .re_i    (r_load),
    .rzero_i (r_resp != RESP_OKAY),
    .raddr_i (word_idx(r_addr)),
    .rdata_o (hp_rdata)
  );

  assign hp_awready = awready_q;
  assign hp_wready  = wready_q;
  assign hp_bvalid  = bvalid_q;
  assign hp_bresp   = bresp_q;
  assign hp_arready = arready_q;
  assign hp_rvalid  = rvalid_q;
  assign hp_rlast   = rlast_q;
  assign hp_rresp   = rresp_q;

endmodule

// File: tb/tb_hp_mem_responder.sv
// Directed bench for hp_mem_responder: write/read-back vector table plus corner sequences.
module tb_hp_mem_responder;

  localparam logic [47:0] BASE = 48'h0000_0001_0000;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [47:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = '0, arsize = '0;
  logic [1:0]   awburst = '0, arburst = '0;
  logic         awvalid = 1'b0, arvalid = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]   bresp, rresp;
  logic [127:0] rdata;

  always #5 clk = ~clk;

  hp_mem_responder #(
    .ADDR_WIDTH(48), .DATA_WIDTH(128), .MEM_DEPTH_LOG2(10), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .hp_awaddr(awaddr), .hp_awlen(awlen), .hp_awsize(awsize), .hp_awburst(awburst),
    .hp_awvalid(awvalid), .hp_awready(awready),
    .hp_wdata(wdata), .hp_wstrb(wstrb), .hp_wlast(wlast), .hp_wvalid(wvalid), .hp_wready(wready),
    .hp_bresp(bresp), .hp_bvalid(bvalid), .hp_bready(bready),
    .hp_araddr(araddr), .hp_arlen(arlen), .hp_arsize(arsize), .hp_arburst(arburst),
    .hp_arvalid(arvalid), .hp_arready(arready),
    .hp_rdata(rdata), .hp_rresp(rresp), .hp_rlast(rlast), .hp_rvalid(rvalid), .hp_rready(rready)
  );

  typedef struct {
    logic [47:0]  off;
    logic [7:0]   len;
    logic [1:0]   burst;
    logic [2:0]   size;
    logic [15:0]  strb;
    logic [127:0] data;
    int           nbeats;
    logic [1:0]   exp_b;
    logic [7:0]   rlen;
    logic [1:0]   rburst;
    logic [2:0]   rsize;
    logic [15:0]  exp_r;
    logic [3:0]   rr;
  } vec_t;

  vec_t         tbl [12];
  logic [127:0] mdl [1024];
  logic [127:0] rd_data [16];
  logic [1:0]   rd_resp [16];
  logic         rd_last [16];
  int           rd_n, rd_cyc;
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic bit minr(input logic [47:0] a);
    return (a >= BASE) && (((a - BASE) >> 4) < 48'd1024);
  endfunction

  function automatic int midx(input logic [47:0] a);
    return int'(10'((a - BASE) >> 4));
  endfunction

  // Reference memory update for a completed write burst.
  task automatic model_write(input logic [47:0] a, input logic [1:0] burst, input logic [2:0] size,
                             input logic [15:0] strb, input logic [127:0] data, input int nb);
    logic [47:0]  ea;
    logic [127:0] d;
    if (size != 3'd4 || burst == 2'b10 || burst == 2'b11) return;
    for (int i = 0; i < nb; i++) begin
      ea = a + ((burst == 2'b01) ? 48'(i * 16) : 48'd0);
      d  = data + 128'(i);
      if (minr(ea))
        for (int b = 0; b < 16; b++)
          if (strb[b]) mdl[midx(ea)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [47:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [15:0] strb, input logic [127:0] data,
                          input int nb, output logic [1:0] br);
    int n;
    br = 2'b01;
    @(negedge clk);
    awaddr = a; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin tmo("aw"); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = data + 128'(i); wstrb = strb; wlast = (i == nb - 1);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin tmo("w"); wvalid = 1'b0; wlast = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin tmo("b"); bready = 1'b0; return; end
    br = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Runs one read burst with rready following rr[cyc%4]; checks stability across stalls.
  task automatic do_read(input logic [47:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] rr);
    int n, cyc;
    bit stalled;
    logic [127:0] hd;
    logic [1:0]   hr;
    rd_n = 0; rd_cyc = 0; stalled = 0; hd = '0; hr = '0;
    @(negedge clk);
    araddr = a; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin tmo("ar"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_first", 128'(rvalid), 128'd1);
    cyc = 0;
    while (rd_n <= int'(len) && cyc < 200) begin
      rready = rr[cyc % 4];
      if (stalled) begin
        chk("stall_rdata", rdata, hd);
        chk("stall_rresp", 128'(rresp), 128'(hr));
      end
      if (rvalid && rready) begin
        if (rd_n < 16) begin
          rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
        end
        rd_n++;
        stalled = 0;
      end else if (rvalid) begin
        stalled = 1; hd = rdata; hr = rresp;
      end else begin
        stalled = 0;
      end
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    rd_cyc = cyc;
    if (rd_n <= int'(len)) tmo("r_beats");
  endtask

  task automatic read_and_check(input logic [47:0] a, input logic [7:0] len, input logic [1:0] burst,
                                input logic [2:0] size, input logic [15:0] exp_r, input logic [3:0] rr,
                                input string tag);
    logic [47:0]  ea;
    logic [1:0]   er;
    logic [127:0] ed;
    do_read(a, len, burst, size, rr);
    chk({tag, " beats"}, 128'(rd_n), 128'(int'(len) + 1));
    if (rr == 4'hF) chk({tag, " cycles"}, 128'(rd_cyc), 128'(int'(len) + 1));
    for (int i = 0; i <= int'(len) && i < rd_n && i < 16; i++) begin
      ea = a + ((burst == 2'b01) ? 48'(i * 16) : 48'd0);
      er = exp_r[2*i +: 2];
      ed = (er != 2'b00) ? 128'd0 : mdl[midx(ea)];
      chk($sformatf("%s b%0d rdata", tag, i), rd_data[i], ed);
      chk($sformatf("%s b%0d rresp", tag, i), 128'(rd_resp[i]), 128'(er));
      chk($sformatf("%s b%0d rlast", tag, i), 128'(rd_last[i]), 128'(i == int'(len)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br;
    logic [47:0] a;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;

    //          off                len    bur    sz     strb      data                                          nb exp_b  rlen  rbur   rsz    exp_r     rr
    tbl[0]  = '{48'h100,          8'd3, 2'b01, 3'd4, 16'hFFFF, 128'h1111_0000_0000_0000_0000_0000_0000_0000, 4, 2'b00, 8'd3, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[1]  = '{48'h200,          8'd0, 2'b01, 3'd4, 16'hFFFF, {128{1'b1}},                                 1, 2'b00, 8'd0, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[2]  = '{48'h200,          8'd0, 2'b01, 3'd4, 16'h00FF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1, 2'b00, 8'd0, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[3]  = '{48'h400,          8'd7, 2'b01, 3'd4, 16'hFFFF, 128'h3333_0000_0000_0000_0000_0000_0000_0000, 8, 2'b00, 8'd7, 2'b01, 3'd4, 16'h0000, 4'b1001};
    tbl[4]  = '{48'h3FE0,         8'd3, 2'b01, 3'd4, 16'hFFFF, 128'h4444_0000_0000_0000_0000_0000_0000_0000, 4, 2'b11, 8'd3, 2'b01, 3'd4, 16'h00F0, 4'hF};
    tbl[5]  = '{48'h600,          8'd3, 2'b01, 3'd4, 16'hFFFF, 128'h5555_0000_0000_0000_0000_0000_0000_0000, 2, 2'b10, 8'd1, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[6]  = '{48'h700,          8'd1, 2'b01, 3'd4, 16'hFFFF, 128'h6666_0000_0000_0000_0000_0000_0000_0000, 2, 2'b00, 8'd1, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[7]  = '{48'h700,          8'd1, 2'b10, 3'd4, 16'hFFFF, 128'h7777_0000_0000_0000_0000_0000_0000_0000, 2, 2'b10, 8'd1, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[8]  = '{48'h800,          8'd2, 2'b00, 3'd4, 16'hFFFF, 128'h8888_0000_0000_0000_0000_0000_0000_0000, 3, 2'b00, 8'd2, 2'b00, 3'd4, 16'h0000, 4'b0101};
    tbl[9]  = '{48'h900,          8'd1, 2'b01, 3'd4, 16'hFFFF, 128'h9999_0000_0000_0000_0000_0000_0000_0000, 3, 2'b10, 8'd2, 2'b01, 3'd4, 16'h0000, 4'hF};
    tbl[10] = '{48'h100,          8'd0, 2'b01, 3'd2, 16'hFFFF, 128'hAAAA_0000_0000_0000_0000_0000_0000_0000, 1, 2'b10, 8'd1, 2'b01, 3'd2, 16'h000A, 4'hF};
    tbl[11] = '{48'hFFFF_FFFF_FFF0, 8'd1, 2'b01, 3'd4, 16'hFFFF, 128'hBBBB_0000_0000_0000_0000_0000_0000_0000, 2, 2'b11, 8'd1, 2'b01, 3'd4, 16'h0003, 4'hF};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst awready", 128'(awready), 128'd1);
    chk("rst arready", 128'(arready), 128'd1);
    chk("rst wready",  128'(wready),  128'd0);
    chk("rst bvalid",  128'(bvalid),  128'd0);
    chk("rst rvalid",  128'(rvalid),  128'd0);
    chk("rst rlast",   128'(rlast),   128'd0);
    chk("rst bresp",   128'(bresp),   128'd0);
    chk("rst rresp",   128'(rresp),   128'd0);
    chk("rst rdata",   rdata,         128'd0);
    rstn = 1'b1;

    for (int r = 0; r < 12; r++) begin
      a = BASE + tbl[r].off;
      do_write(a, tbl[r].len, tbl[r].burst, tbl[r].size, tbl[r].strb, tbl[r].data, tbl[r].nbeats, br);
      chk($sformatf("row%0d bresp", r), 128'(br), 128'(tbl[r].exp_b));
      model_write(a, tbl[r].burst, tbl[r].size, tbl[r].strb, tbl[r].data, tbl[r].nbeats);
      read_and_check(a, tbl[r].rlen, tbl[r].rburst, tbl[r].rsize, tbl[r].exp_r, tbl[r].rr,
                     $sformatf("row%0d", r));
    end

    // Partial strobe merge, hand-computed.
    do_read(BASE + 48'h200, 8'd0, 2'b01, 3'd4, 4'hF);
    chk("strb merge", rd_data[0], 128'hFFFF_FFFF_FFFF_FFFF_8899_AABB_CCDD_EEFF);

    // Same-cycle write and read of one word: read must return the old contents.
    @(negedge clk);
    awaddr = BASE + 48'h100; awlen = 8'd0; awburst = 2'b01; awsize = 3'd4; awvalid = 1'b1;
    chk("rw awready", 128'(awready), 128'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D; wstrb = 16'hFFFF; wlast = 1'b1;
    araddr = BASE + 48'h100; arlen = 8'd0; arburst = 2'b01; arsize = 3'd4; arvalid = 1'b1;
    chk("rw wready", 128'(wready), 128'd1);
    chk("rw arready", 128'(arready), 128'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("rw rvalid", 128'(rvalid), 128'd1);
    chk("rw old data", rdata, 128'h1111_0000_0000_0000_0000_0000_0000_0000);
    chk("rw rlast", 128'(rlast), 128'd1);
    chk("rw bvalid", 128'(bvalid), 128'd1);
    chk("rw bresp", 128'(bresp), 128'd0);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    model_write(BASE + 48'h100, 2'b01, 3'd4, 16'hFFFF, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, 1);
    read_and_check(BASE + 48'h100, 8'd0, 2'b01, 3'd4, 16'h0000, 4'hF, "rw new");

    // Reset in the middle of a read burst.
    @(negedge clk);
    araddr = BASE + 48'h400; arlen = 8'd7; arburst = 2'b01; arsize = 3'd4; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid rvalid", 128'(rvalid), 128'd1);
    rstn = 1'b0;
    #1;
    chk("mid-rst rvalid", 128'(rvalid), 128'd0);
    chk("mid-rst arready", 128'(arready), 128'd1);
    chk("mid-rst awready", 128'(awready), 128'd1);
    chk("mid-rst rdata", rdata, 128'd0);
    @(negedge clk);
    rready = 1'b0;
    rstn = 1'b1;
    do_write(BASE + 48'hA00, 8'd1, 2'b01, 3'd4, 16'hFFFF, 128'hCCCC_0000_0000_0000_0000_0000_0000_0000, 2, br);
    chk("post-rst bresp", 128'(br), 128'd0);
    model_write(BASE + 48'hA00, 2'b01, 3'd4, 16'hFFFF, 128'hCCCC_0000_0000_0000_0000_0000_0000_0000, 2);
    read_and_check(BASE + 48'hA00, 8'd1, 2'b01, 3'd4, 16'h0000, 4'hF, "post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
